// File: rtl/drive_thermal_sequencer.sv
// drive_thermal_sequencer
//   Sequencing controller for the vehicle keep_driving / shut_off_computer
//   controls. Two independent FSMs share one clock edge:
//     - a thermal FSM that debounces cpu_overheated before shutting the
//       computer off, then holds it off for a minimum cool-down;
//     - a trip FSM (parked / drive / refuel / arrived).
//   Saturating counters record completed trips and thermal shutdowns.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   T_RUN    | computer on; counting consecutive hot samples
//   T_OFF    | computer off; counting consecutive cool samples
//   PARKED   | idle, waiting for an unblocked start_trip
//   DRIVE    | driving; keep_driving follows the thermal FSM
//   REFUEL   | tank empty, waiting for refuel_done with a full tank
//   ARRIVED  | destination reached, waiting for arrived to drop
//
// Ports
//   clk, areset_n      clock (rising edge), async active-low reset
//   cpu_overheated     raw thermal flag
//   arrived            destination reached (level)
//   gas_tank_empty     fuel empty (level)
//   start_trip         one-cycle request to begin driving
//   refuel_done        one-cycle refuel completion pulse
//   shut_off_computer  registered computer power-off command
//   keep_driving       registered drive enable
//   drive_state        00 PARKED, 01 DRIVE, 10 REFUEL, 11 ARRIVED
//   trip_count         completed trips, saturating
//   shutdown_count     thermal shutdowns, saturating
module drive_thermal_sequencer #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int COOLDOWN_CYC = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             cpu_overheated,
    input  logic             arrived,
    input  logic             gas_tank_empty,
    input  logic             start_trip,
    input  logic             refuel_done,
    output logic             shut_off_computer,
    output logic             keep_driving,
    output logic [1:0]       drive_state,
    output logic [CNT_W-1:0] trip_count,
    output logic [CNT_W-1:0] shutdown_count
);

    localparam int HW = $clog2(DEBOUNCE_CYC + 1);
    localparam int CW = $clog2(COOLDOWN_CYC + 1);

    // Debounce and cool-down timers are down-counters: they are loaded with
    // the run length and the qualifying sample is the one seen at count 1.
    localparam logic [HW-1:0]    HOT_LOAD  = HW'(DEBOUNCE_CYC);
    localparam logic [HW-1:0]    HOT_ONE   = HW'(1);
    localparam logic [CW-1:0]    COOL_LOAD = CW'(COOLDOWN_CYC);
    localparam logic [CW-1:0]    COOL_ONE  = CW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        T_RUN = 1'b0,
        T_OFF = 1'b1
    } therm_t;

    typedef enum logic [1:0] {
        PARKED  = 2'b00,
        DRIVE   = 2'b01,
        REFUEL  = 2'b10,
        ARRIVED = 2'b11
    } drive_t;

    therm_t           therm_q, therm_d;
    drive_t           drv_q, drv_d;
    logic [HW-1:0]    hot_q, hot_d;
    logic [CW-1:0]    cool_q, cool_d;
    logic [CNT_W-1:0] trip_q, trip_d;
    logic [CNT_W-1:0] sd_q, sd_d;
    logic             keep_q, keep_d;
    logic             trip_done;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            therm_q <= T_RUN;
            drv_q   <= PARKED;
            hot_q   <= HOT_LOAD;
            cool_q  <= COOL_LOAD;
            trip_q  <= '0;
            sd_q    <= '0;
            keep_q  <= 1'b0;
        end else begin
            therm_q <= therm_d;
            drv_q   <= drv_d;
            hot_q   <= hot_d;
            cool_q  <= cool_d;
            trip_q  <= trip_d;
            sd_q    <= sd_d;
            keep_q  <= keep_d;
        end
    end

    always_comb begin
        therm_d   = therm_q;
        hot_d     = hot_q;
        cool_d    = cool_q;
        sd_d      = sd_q;
        drv_d     = drv_q;
        trip_d    = trip_q;
        trip_done = 1'b0;

        // Thermal FSM. Each state keeps the other state's timer parked at its
        // load value so a re-entry always needs a full new run.
        if (therm_q == T_RUN) begin
            cool_d = COOL_LOAD;
            if (cpu_overheated) begin
                if (hot_q == HOT_ONE) begin
                    therm_d = T_OFF;
                    hot_d   = HOT_LOAD;
                    if (sd_q != CNT_MAX) sd_d = sd_q + 1'b1;
                end else begin
                    hot_d = hot_q - 1'b1;
                end
            end else begin
                hot_d = HOT_LOAD;
            end
        end else begin
            hot_d = HOT_LOAD;
            if (!cpu_overheated) begin
                if (cool_q == COOL_ONE) begin
                    therm_d = T_RUN;
                    cool_d  = COOL_LOAD;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end else begin
                cool_d = COOL_LOAD;
            end
        end

        // Trip FSM. arrived wins over every other condition in DRIVE/REFUEL.
        case (drv_q)
            PARKED: begin
                if (start_trip && !arrived && !gas_tank_empty) drv_d = DRIVE;
            end
            DRIVE: begin
                if (arrived) begin
                    drv_d     = ARRIVED;
                    trip_done = 1'b1;
                end else if (gas_tank_empty) begin
                    drv_d = REFUEL;
                end
            end
            REFUEL: begin
                if (arrived) begin
                    drv_d     = ARRIVED;
                    trip_done = 1'b1;
                end else if (refuel_done && !gas_tank_empty) begin
                    drv_d = DRIVE;
                end
            end
            ARRIVED: begin
                if (!arrived) drv_d = PARKED;
            end
        endcase

        if (trip_done && (trip_q != CNT_MAX)) trip_d = trip_q + 1'b1;

        // Looks at the next states so a shutdown and the drive enable drop
        // on the same edge.
        keep_d = (drv_d == DRIVE) && (therm_d == T_RUN);
    end

    assign shut_off_computer = (therm_q == T_OFF);
    assign keep_driving      = keep_q;
    assign drive_state       = drv_q;
    assign trip_count        = trip_q;
    assign shutdown_count    = sd_q;

endmodule

// File: tb/tb_drive_thermal_sequencer.sv
module tb_drive_thermal_sequencer;

    localparam int D  = 4;
    localparam int C  = 16;
    localparam int CMAX = 255;

    logic clk;
    logic areset_n;
    logic hot, arr, gas, st, rf;
    logic shut, keep;
    logic [1:0] dstate;
    logic [7:0] trips, sds;

    // Second instance: 2-bit counters and 1-cycle timers for saturation.
    logic s_hot, s_arr, s_gas, s_st, s_rf;
    logic s_shut, s_keep;
    logic [1:0] s_dstate;
    logic [1:0] s_trips, s_sds;

    int n_checks;
    int n_errors;

    // Reference model state: streaks count up from 0, drive state as int.
    int m_drv, m_streak, m_trip, m_sd;
    bit m_off;

    typedef struct {
        logic hot, arr, gas, st, rf;
        int   e_state;
        logic e_keep;
        int   e_trip;
    } vec_t;

    vec_t vecs[$];

    drive_thermal_sequencer #(.DEBOUNCE_CYC(D), .COOLDOWN_CYC(C), .CNT_W(8)) dut (
        .clk(clk), .areset_n(areset_n), .cpu_overheated(hot), .arrived(arr),
        .gas_tank_empty(gas), .start_trip(st), .refuel_done(rf),
        .shut_off_computer(shut), .keep_driving(keep), .drive_state(dstate),
        .trip_count(trips), .shutdown_count(sds)
    );

    drive_thermal_sequencer #(.DEBOUNCE_CYC(1), .COOLDOWN_CYC(1), .CNT_W(2)) dut_sat (
        .clk(clk), .areset_n(areset_n), .cpu_overheated(s_hot), .arrived(s_arr),
        .gas_tank_empty(s_gas), .start_trip(s_st), .refuel_done(s_rf),
        .shut_off_computer(s_shut), .keep_driving(s_keep), .drive_state(s_dstate),
        .trip_count(s_trips), .shutdown_count(s_sds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_drv = 0; m_streak = 0; m_trip = 0; m_sd = 0; m_off = 0;
    endtask

    task automatic m_step();
        if (!m_off) begin
            m_streak = hot ? m_streak + 1 : 0;
            if (m_streak == D) begin
                m_off = 1; m_streak = 0;
                if (m_sd < CMAX) m_sd++;
            end
        end else begin
            m_streak = !hot ? m_streak + 1 : 0;
            if (m_streak == C) begin
                m_off = 0; m_streak = 0;
            end
        end
        case (m_drv)
            0: if (st && !arr && !gas) m_drv = 1;
            1: if (arr) begin m_drv = 3; if (m_trip < CMAX) m_trip++; end
               else if (gas) m_drv = 2;
            2: if (arr) begin m_drv = 3; if (m_trip < CMAX) m_trip++; end
               else if (rf && !gas) m_drv = 1;
            default: if (!arr) m_drv = 0;
        endcase
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"}, 32'(dstate), 32'(m_drv));
        chk({tag, ".keep"},  32'(keep),   32'((m_drv == 1) && !m_off));
        chk({tag, ".shut"},  32'(shut),   32'(m_off));
        chk({tag, ".trips"}, 32'(trips),  32'(m_trip));
        chk({tag, ".sds"},   32'(sds),    32'(m_sd));
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic set_in(input logic h, input logic a, input logic g, input logic s, input logic r);
        hot = h; arr = a; gas = g; st = s; rf = r;
    endtask

    task automatic add_vec(input logic h, a, g, s, r, input int es, input logic ek, input int et);
        vec_t v;
        v.hot = h; v.arr = a; v.gas = g; v.st = s; v.rf = r;
        v.e_state = es; v.e_keep = ek; v.e_trip = et;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_reset();
        areset_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        s_hot = 0; s_arr = 0; s_gas = 0; s_st = 0; s_rf = 0;

        //        hot arr gas st rf   state keep trip
        add_vec(0, 0, 0, 1, 0,   1, 1, 0);
        add_vec(0, 0, 0, 0, 0,   1, 1, 0);
        add_vec(0, 1, 0, 0, 0,   3, 0, 1);
        add_vec(0, 1, 0, 0, 0,   3, 0, 1);
        add_vec(0, 0, 0, 0, 0,   0, 0, 1);
        add_vec(0, 1, 0, 1, 0,   0, 0, 1);
        add_vec(0, 0, 1, 1, 0,   0, 0, 1);
        add_vec(0, 0, 0, 1, 0,   1, 1, 1);
        add_vec(0, 0, 1, 0, 0,   2, 0, 1);
        add_vec(0, 0, 1, 0, 1,   2, 0, 1);
        add_vec(0, 0, 0, 0, 0,   2, 0, 1);
        add_vec(0, 0, 0, 0, 1,   1, 1, 1);
        add_vec(0, 1, 1, 0, 0,   3, 0, 2);
        add_vec(0, 1, 0, 1, 0,   3, 0, 2);
        add_vec(0, 0, 0, 0, 0,   0, 0, 2);
        add_vec(0, 0, 0, 1, 0,   1, 1, 2);
        add_vec(0, 0, 1, 0, 0,   2, 0, 2);
        add_vec(0, 1, 1, 0, 0,   3, 0, 3);
        add_vec(0, 0, 0, 0, 0,   0, 0, 3);

        // Reset held, outputs at 0 before any edge is released.
        #12;
        chk("rst.shut", 32'(shut), 0);
        chk("rst.keep", 32'(keep), 0);
        chk("rst.state", 32'(dstate), 0);
        @(negedge clk);
        areset_n = 1'b1;
        tick();
        chk_model("post_rst");

        // Table-driven trip sequence.
        foreach (vecs[i]) begin
            set_in(vecs[i].hot, vecs[i].arr, vecs[i].gas, vecs[i].st, vecs[i].rf);
            tick();
            chk($sformatf("vec%0d.state", i), 32'(dstate), 32'(vecs[i].e_state));
            chk($sformatf("vec%0d.keep", i),  32'(keep),   32'(vecs[i].e_keep));
            chk($sformatf("vec%0d.trip", i),  32'(trips),  32'(vecs[i].e_trip));
            chk($sformatf("vec%0d.shut", i),  32'(shut),   0);
        end

        // Enter DRIVE, then debounce: 3 hot, 1 cool, 4 hot.
        set_in(0, 0, 0, 1, 0); tick();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            hot = 1; tick();
            chk("deb.short_run", 32'(shut), 0);
        end
        hot = 0; tick();
        for (int i = 0; i < 4; i++) begin
            hot = 1; tick();
            chk_model("deb");
        end
        chk("deb.shut", 32'(shut), 1);
        chk("deb.keep", 32'(keep), 0);
        chk("deb.sds", 32'(sds), 1);
        chk("deb.state", 32'(dstate), 1);

        // Cool-down: 15 low, 1 high, 16 low.
        hot = 0;
        for (int i = 0; i < 15; i++) begin tick(); chk_model("cool_a"); end
        chk("cool.after15", 32'(shut), 1);
        hot = 1; tick(); chk("cool.hot_blip", 32'(shut), 1);
        hot = 0;
        for (int i = 0; i < 15; i++) begin tick(); chk_model("cool_b"); end
        chk("cool.after31", 32'(shut), 1);
        tick();
        chk("cool.release", 32'(shut), 0);
        chk("cool.keep", 32'(keep), 1);

        // Reset mid-debounce aborts the pending hot run.
        hot = 1;
        for (int i = 0; i < 3; i++) tick();
        #3;
        areset_n = 1'b0;
        #1;
        m_reset();
        chk("mid_rst.keep", 32'(keep), 0);
        chk("mid_rst.state", 32'(dstate), 0);
        chk("mid_rst.trips", 32'(trips), 0);
        chk("mid_rst.sds", 32'(sds), 0);
        @(negedge clk);
        areset_n = 1'b1;
        tick();
        chk("mid_rst.no_shut", 32'(shut), 0);
        chk_model("mid_rst");

        // Randomized phase against the model; hot bias toggles to reach both
        // debounce and cool-down runs.
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = ((i / 48) % 2 == 0) ? 85 : 8;
            hot = ($urandom_range(0, 99) < p);
            arr = ($urandom_range(0, 99) < 12);
            gas = ($urandom_range(0, 99) < 15);
            st  = ($urandom_range(0, 99) < 25);
            rf  = ($urandom_range(0, 99) < 30);
            tick();
            chk_model("rnd");
        end
        set_in(0, 0, 0, 0, 0);

        // Saturation on the 2-bit instance: 5 trips and 5 shutdowns.
        for (int i = 0; i < 5; i++) begin
            int e;
            e = (i + 1 > 3) ? 3 : i + 1;
            s_st = 1; tick();
            s_st = 0; s_arr = 1; s_hot = 1; tick();
            chk("sat.shut", 32'(s_shut), 1);
            chk("sat.trips", 32'(s_trips), 32'(e));
            chk("sat.sds", 32'(s_sds), 32'(e));
            s_arr = 0; s_hot = 0; tick();
            chk("sat.parked", 32'(s_dstate), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
